// File: rtl/activation_load_sequencer_if.sv
// activation_load_sequencer_if: start/stream inputs and bank write-side outputs of the load sequencer
interface activation_load_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BRAM_COUNT = 5,
  parameter int CNT_WIDTH  = 7
) ();
  logic                  start;
  logic [CNT_WIDTH-1:0]  num_words;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [BRAM_COUNT-1:0] en_bus;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (
    output start, num_words, base_addr, in_valid, in_data,
    input  in_ready, en_bus, w_addr, data_in, busy, done, err
  );
  modport slave (
    input  start, num_words, base_addr, in_valid, in_data,
    output in_ready, en_bus, w_addr, data_in, busy, done, err
  );
endinterface

// File: rtl/activation_load_sequencer.sv
// activation_load_sequencer: stripes a valid/ready word stream round-robin across banks; optional overflow clamp via ACT_LOAD_OVF_CHECK_EN
module activation_load_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BRAM_COUNT = 5,
  parameter int CNT_WIDTH  = 7
) (
  input logic clk,
  input logic rst,
  activation_load_sequencer_if.slave bus
);
  localparam int BW = BRAM_COUNT > 1 ? $clog2(BRAM_COUNT) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d, load_n;
  logic [BW-1:0]         bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d, waddr_q, waddr_d;
  logic [BRAM_COUNT-1:0] en_q, en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d, beat, ovf, last_bank;
`ifdef ACT_LOAD_OVF_CHECK_EN
  logic [CNT_WIDTH-1:0] cap;
  // rows left from base_addr to the top of each bank, times the bank count
  assign cap = CNT_WIDTH'(BRAM_COUNT) * (CNT_WIDTH'(2**ADDR_WIDTH) - CNT_WIDTH'(bus.base_addr));
  assign ovf = bus.num_words > cap;
  assign load_n = ovf ? cap : bus.num_words;
`else
  assign ovf = 1'b0;
  assign load_n = bus.num_words;
`endif
  assign beat = bus.in_valid && state_q == LOAD;
  assign last_bank = bank_q == BW'(BRAM_COUNT - 1);
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    bank_d = bank_q;
    row_d = row_q;
    err_d = err_q;
    en_d = beat ? BRAM_COUNT'(1) << bank_q : '0;
    waddr_d = beat ? row_q : waddr_q;
    data_d = beat ? bus.in_data : data_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = bus.num_words == '0 ? DONE : LOAD;
        rem_d = load_n;
        bank_d = '0;
        row_d = bus.base_addr;
        err_d = ovf;
      end
      LOAD: if (beat) begin
        rem_d = rem_q - 1'b1;
        bank_d = last_bank ? '0 : bank_q + 1'b1;
        row_d = last_bank ? row_q + 1'b1 : row_q;
        state_d = rem_q == CNT_WIDTH'(1) ? DRAIN : LOAD;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      bank_q <= '0;
      row_q <= '0;
      waddr_q <= '0;
      en_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      bank_q <= bank_d;
      row_q <= row_d;
      waddr_q <= waddr_d;
      en_q <= en_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign bus.in_ready = state_q == LOAD;
  assign bus.busy = state_q == LOAD || state_q == DRAIN;
  assign bus.done = state_q == DONE;
  assign bus.en_bus = en_q;
  assign bus.w_addr = waddr_q;
  assign bus.data_in = data_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_activation_load_sequencer.sv
// tb_activation_load_sequencer: table-driven and randomized loads checked against a word-index write model
module tb_activation_load_sequencer;
  localparam int AW = 4, DW = 8, BC = 5, CW = 7;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  activation_load_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_COUNT(BC), .CNT_WIDTH(CW)) ifc ();
  activation_load_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_COUNT(BC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );
  always #5 clk = ~clk;

  typedef struct {
    int num;
    int base;
    int mode;
    bit restart;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int eff_count(input int n, input int b);
`ifdef ACT_LOAD_OVF_CHECK_EN
    return n > BC * (2**AW - b) ? BC * (2**AW - b) : n;
`else
    return n;
`endif
  endfunction

  task automatic chk_write(input bit pend, input int pb, input int pr, input logic [DW-1:0] pd);
    if (pend) begin
      chk("en_bus", 32'(ifc.en_bus), 32'(1 << pb));
      chk("w_addr", 32'(ifc.w_addr), 32'(pr));
      chk("data_in", 32'(ifc.data_in), 32'(pd));
    end else chk("en_idle", 32'(ifc.en_bus), 0);
  endtask

  task automatic run_load(input int num, input int base, input int mode, input bit restart);
    int n_eff, k, cyc, pb, pr;
    bit pend;
    logic v;
    logic [DW-1:0] pd;
    n_eff = eff_count(num, base);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.num_words = CW'(num);
    ifc.base_addr = AW'(base);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    if (n_eff == 0) begin
      chk("zero_done", 32'(ifc.done), 1);
      chk("zero_en", 32'(ifc.en_bus), 0);
      chk("zero_ready", 32'(ifc.in_ready), 0);
      chk("zero_busy", 32'(ifc.busy), 0);
      @(negedge clk);
      chk("zero_done_end", 32'(ifc.done), 0);
      chk("zero_ready_end", 32'(ifc.in_ready), 0);
      return;
    end
    k = 0;
    cyc = 0;
    pend = 1'b0;
    pb = 0;
    pr = 0;
    pd = '0;
    while (k < n_eff) begin
      chk_write(pend, pb, pr, pd);
      chk("in_ready", 32'(ifc.in_ready), 1);
      chk("busy", 32'(ifc.busy), 1);
      chk("done_early", 32'(ifc.done), 0);
      v = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ifc.in_valid = v;
      ifc.in_data = DW'($urandom);
      if (restart && cyc == 2) begin
        ifc.start = 1'b1;
        ifc.num_words = CW'(3);
        ifc.base_addr = AW'(9);
      end
      pend = v;
      pb = k % BC;
      pr = (base + k / BC) % (2**AW);
      pd = ifc.in_data;
      if (v) k++;
      @(negedge clk);
      ifc.start = 1'b0;
      cyc++;
      if (cyc > 2000) begin
        chk("load_timeout", 1, 0);
        break;
      end
    end
    ifc.in_valid = 1'b0;
    chk_write(pend, pb, pr, pd);
    chk("drain_ready", 32'(ifc.in_ready), 0);
    chk("drain_busy", 32'(ifc.busy), 1);
    chk("drain_done", 32'(ifc.done), 0);
    @(negedge clk);
    chk("done", 32'(ifc.done), 1);
    chk("done_busy", 32'(ifc.busy), 0);
    chk("done_en", 32'(ifc.en_bus), 0);
    chk("err", 32'(ifc.err), 32'(n_eff < num));
    @(negedge clk);
    chk("done_end", 32'(ifc.done), 0);
    chk("idle_ready", 32'(ifc.in_ready), 0);
  endtask

  initial begin
    vecs[0] = '{num: 7, base: 2, mode: 0, restart: 1'b0};
    vecs[1] = '{num: 7, base: 2, mode: 1, restart: 1'b0};
    vecs[2] = '{num: 0, base: 5, mode: 0, restart: 1'b0};
    vecs[3] = '{num: 7, base: 2, mode: 0, restart: 1'b1};
    vecs[4] = '{num: 12, base: 14, mode: 0, restart: 1'b0};
    vecs[5] = '{num: 1, base: 0, mode: 0, restart: 1'b0};
    vecs[6] = '{num: 80, base: 0, mode: 0, restart: 1'b0};
    vecs[7] = '{num: 9, base: 15, mode: 1, restart: 1'b0};
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.num_words = '0;
    ifc.base_addr = '0;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    #2;
    chk("rst_en", 32'(ifc.en_bus), 0);
    chk("rst_ready", 32'(ifc.in_ready), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_err", 32'(ifc.err), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_load(vecs[i].num, vecs[i].base, vecs[i].mode, vecs[i].restart);
    for (int i = 0; i < 12; i++) run_load(int'($urandom_range(0, 40)), int'($urandom_range(0, 15)), 2, 1'b0);
    // asynchronous reset in the middle of a streaming load
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.num_words = CW'(20);
    ifc.base_addr = AW'(0);
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_en", 32'(ifc.en_bus != 0), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(ifc.en_bus), 0);
    chk("mid_rst_ready", 32'(ifc.in_ready), 0);
    chk("mid_rst_busy", 32'(ifc.busy), 0);
    chk("mid_rst_waddr", 32'(ifc.w_addr), 0);
    chk("mid_rst_data", 32'(ifc.data_in), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(ifc.in_ready), 0);
      chk("post_rst_en", 32'(ifc.en_bus), 0);
    end
    ifc.in_valid = 1'b0;
    run_load(7, 2, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
